// File: rtl/cobalt_pkg.sv
// rtl/cobalt_pkg.sv - shared widths, entry type and popcount helper for the register status table
package cobalt_pkg;

  localparam int W_ADDR  = 5;
  localparam int W_TAG   = 6;
  localparam int N_ENTRY = 2 ** W_ADDR;

  typedef struct packed {
    logic             busy;
    logic [W_TAG-1:0] tag;
  } rst_entry_t;

  // Number of set bits in a full busy vector; result fits 0..N_ENTRY
  function automatic logic [W_ADDR:0] popcount(input logic [N_ENTRY-1:0] v);
    logic [W_ADDR:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      cnt = cnt + {{W_ADDR{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rst_entry.sv
// rtl/rst_entry.sv - one busy/tag entry with CDB tag compare
module rst_entry
  import cobalt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             set,
  input  logic [W_TAG-1:0] set_tag,
  input  logic             cdb_valid,
  input  logic [W_TAG-1:0] cdb_tag,
  output logic             match,
  output logic             busy_next,
  output rst_entry_t       entry
);

  rst_entry_t entry_r;

  assign match = cdb_valid & entry_r.busy & (entry_r.tag == cdb_tag);
  assign entry = entry_r;

  // Flush beats a new rename, which beats a CDB clear of the old producer
  always_comb begin
    busy_next = entry_r.busy;
    if (flush)      busy_next = 1'b0;
    else if (set)   busy_next = 1'b1;
    else if (match) busy_next = 1'b0;
  end

  // Busy follows the priority above; the tag only changes on a rename
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_r <= '0;
    end else begin
      entry_r.busy <= busy_next;
      if (set) entry_r.tag <= set_tag;
    end
  end

endmodule

// File: rtl/reg_status_table.sv
// rtl/reg_status_table.sv - per-register busy/tag table with CDB write enables and source lookups
module reg_status_table
  import cobalt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               dispatch_en,
  input  logic [W_ADDR-1:0]  dispatch_rdaddr,
  input  logic [W_TAG-1:0]   dispatch_rdtag,
  input  logic [W_ADDR-1:0]  dispatch_rsaddr,
  input  logic [W_ADDR-1:0]  dispatch_rtaddr,
  input  logic               cdb_valid,
  input  logic [W_TAG-1:0]   cdb_tag,
  output logic [N_ENTRY-1:0] rst_wen_onehot,
  output logic               rst_rs_busy,
  output logic [W_TAG-1:0]   rst_rs_tag,
  output logic               rst_rs_cdbfwd,
  output logic               rst_rt_busy,
  output logic [W_TAG-1:0]   rst_rt_tag,
  output logic               rst_rt_cdbfwd,
  output logic [W_ADDR:0]    rst_busy_count
);

  logic [N_ENTRY-1:0] match_vec;
  logic [N_ENTRY-1:0] busy_vec;
  logic [N_ENTRY-1:0] busy_next_vec;
  logic [N_ENTRY-1:0] tag_dup_vec;
  logic [W_TAG-1:0]   tag_arr [N_ENTRY];

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRY; gi++) begin : g_entry
      rst_entry_t entry;
      logic       set;

      // Register 0 is hardwired, so it is never renamed and never goes busy
      assign set = dispatch_en & ~flush & (gi != 0) &
                   (dispatch_rdaddr == W_ADDR'(gi));

      rst_entry u_entry (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .set       (set),
        .set_tag   (dispatch_rdtag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .match     (match_vec[gi]),
        .busy_next (busy_next_vec[gi]),
        .entry     (entry)
      );

      assign busy_vec[gi]    = entry.busy;
      assign tag_arr[gi]     = entry.tag;
      assign tag_dup_vec[gi] = entry.busy & ~match_vec[gi] & (entry.tag == dispatch_rdtag);
    end
  endgenerate

  assign rst_wen_onehot = match_vec;

  // Source lookups read pre-update state; a CDB hit turns a pending source into a forward
  always_comb begin
    rst_rs_cdbfwd = (dispatch_rsaddr != '0) & match_vec[dispatch_rsaddr];
    rst_rs_busy   = (dispatch_rsaddr != '0) & busy_vec[dispatch_rsaddr] & ~match_vec[dispatch_rsaddr];
    rst_rs_tag    = rst_rs_busy ? tag_arr[dispatch_rsaddr] : '0;
    rst_rt_cdbfwd = (dispatch_rtaddr != '0) & match_vec[dispatch_rtaddr];
    rst_rt_busy   = (dispatch_rtaddr != '0) & busy_vec[dispatch_rtaddr] & ~match_vec[dispatch_rtaddr];
    rst_rt_tag    = rst_rt_busy ? tag_arr[dispatch_rtaddr] : '0;
  end

  // Count tracks the busy vector that the entries are about to load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_busy_count <= '0;
    else       rst_busy_count <= popcount(busy_next_vec);
  end

`ifndef SYNTHESIS
  // Tags are unique among live producers, so at most one register can match
  assert property (@(posedge clk) disable iff (reset) $onehot0(rst_wen_onehot))
    else $error("FATAL: reg_status_table multiple CDB write enables");

  // A tag handed out again while a live entry still waits on it would alias
  assert property (@(posedge clk) disable iff (reset)
                   !(dispatch_en & ~flush & (dispatch_rdaddr != '0) & (|tag_dup_vec)))
    else $error("FATAL: reg_status_table dispatch tag already in use");
`endif

endmodule

// File: tb/tb_reg_status_table.sv
// tb/tb_reg_status_table.sv - table-driven bench for reg_status_table
module tb_reg_status_table;
  import cobalt_pkg::*;

  logic               clk;
  logic               reset;
  logic               flush;
  logic               dispatch_en;
  logic [W_ADDR-1:0]  dispatch_rdaddr;
  logic [W_TAG-1:0]   dispatch_rdtag;
  logic [W_ADDR-1:0]  dispatch_rsaddr;
  logic [W_ADDR-1:0]  dispatch_rtaddr;
  logic               cdb_valid;
  logic [W_TAG-1:0]   cdb_tag;
  logic [N_ENTRY-1:0] rst_wen_onehot;
  logic               rst_rs_busy;
  logic [W_TAG-1:0]   rst_rs_tag;
  logic               rst_rs_cdbfwd;
  logic               rst_rt_busy;
  logic [W_TAG-1:0]   rst_rt_tag;
  logic               rst_rt_cdbfwd;
  logic [W_ADDR:0]    rst_busy_count;

  int errors = 0;
  int checks = 0;

  reg_status_table dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .dispatch_en     (dispatch_en),
    .dispatch_rdaddr (dispatch_rdaddr),
    .dispatch_rdtag  (dispatch_rdtag),
    .dispatch_rsaddr (dispatch_rsaddr),
    .dispatch_rtaddr (dispatch_rtaddr),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .rst_wen_onehot  (rst_wen_onehot),
    .rst_rs_busy     (rst_rs_busy),
    .rst_rs_tag      (rst_rs_tag),
    .rst_rs_cdbfwd   (rst_rs_cdbfwd),
    .rst_rt_busy     (rst_rt_busy),
    .rst_rt_tag      (rst_rt_tag),
    .rst_rt_cdbfwd   (rst_rt_cdbfwd),
    .rst_busy_count  (rst_busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               fl;
    logic               de;
    logic [W_ADDR-1:0]  rd;
    logic [W_TAG-1:0]   rdt;
    logic [W_ADDR-1:0]  rs;
    logic [W_ADDR-1:0]  rt;
    logic               cv;
    logic [W_TAG-1:0]   ct;
    logic [N_ENTRY-1:0] wen;
    logic               rsb;
    logic [W_TAG-1:0]   rst;
    logic               rsf;
    logic               rtb;
    logic [W_TAG-1:0]   rtt;
    logic               rtf;
    logic [W_ADDR:0]    cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic de, input logic [W_ADDR-1:0] rd,
                       input logic [W_TAG-1:0] rdt, input logic [W_ADDR-1:0] rs,
                       input logic [W_ADDR-1:0] rt, input logic cv, input logic [W_TAG-1:0] ct);
    flush = fl; dispatch_en = de; dispatch_rdaddr = rd; dispatch_rdtag = rdt;
    dispatch_rsaddr = rs; dispatch_rtaddr = rt; cdb_valid = cv; cdb_tag = ct;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 6'd0, 5'd0, 5'd0, 1'b0, 6'd0);
  endtask

  initial begin
    //          fl    de    rd      rdt     rs      rt      cv    ct       wen            rsb   rst     rsf   rtb   rtt     rtf   cnt
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd7,  5'd3,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};
    vecs[1]  = '{1'b0, 1'b1, 5'd7,  6'h12, 5'd7,  5'd0,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd7,  5'd7,  1'b0, 6'h00, 32'h0000_0000, 1'b1, 6'h12, 1'b0, 1'b1, 6'h12, 1'b0, 6'd1};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd7,  5'd3,  1'b1, 6'h12, 32'h0000_0080, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0, 6'd1};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd7,  5'd0,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};
    vecs[5]  = '{1'b0, 1'b1, 5'd3,  6'h05, 5'd3,  5'd0,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};
    vecs[6]  = '{1'b0, 1'b1, 5'd3,  6'h09, 5'd3,  5'd3,  1'b0, 6'h00, 32'h0000_0000, 1'b1, 6'h05, 1'b0, 1'b1, 6'h05, 1'b0, 6'd1};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd3,  5'd0,  1'b1, 6'h05, 32'h0000_0000, 1'b1, 6'h09, 1'b0, 1'b0, 6'h00, 1'b0, 6'd1};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd3,  5'd0,  1'b1, 6'h09, 32'h0000_0008, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0, 6'd1};
    vecs[9]  = '{1'b0, 1'b1, 5'd4,  6'h02, 5'd4,  5'd3,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};
    vecs[10] = '{1'b0, 1'b1, 5'd4,  6'h0b, 5'd4,  5'd4,  1'b1, 6'h02, 32'h0000_0010, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1, 6'd1};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd4,  5'd0,  1'b0, 6'h00, 32'h0000_0000, 1'b1, 6'h0b, 1'b0, 1'b0, 6'h00, 1'b0, 6'd1};
    vecs[12] = '{1'b0, 1'b1, 5'd0,  6'h01, 5'd0,  5'd4,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b1, 6'h0b, 1'b0, 6'd1};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd0,  5'd0,  1'b1, 6'h01, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd1};
    vecs[14] = '{1'b0, 1'b1, 5'd5,  6'h14, 5'd5,  5'd4,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b1, 6'h0b, 1'b0, 6'd1};
    vecs[15] = '{1'b0, 1'b1, 5'd6,  6'h15, 5'd5,  5'd6,  1'b0, 6'h00, 32'h0000_0000, 1'b1, 6'h14, 1'b0, 1'b0, 6'h00, 1'b0, 6'd2};
    vecs[16] = '{1'b1, 1'b1, 5'd6,  6'h1e, 5'd5,  5'd6,  1'b1, 6'h14, 32'h0000_0020, 1'b0, 6'h00, 1'b1, 1'b1, 6'h15, 1'b0, 6'd3};
    vecs[17] = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd6,  5'd4,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};
    vecs[18] = '{1'b0, 1'b1, 5'd31, 6'h3f, 5'd31, 5'd0,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};
    vecs[19] = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd31, 5'd31, 1'b1, 6'h3f, 32'h8000_0000, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1, 6'd1};
    vecs[20] = '{1'b0, 1'b0, 5'd0,  6'h00, 5'd31, 5'd0,  1'b0, 6'h00, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 6'd0};

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Inputs change on the falling edge; outputs are sampled 2 time units later
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fl, vecs[i].de, vecs[i].rd, vecs[i].rdt,
            vecs[i].rs, vecs[i].rt, vecs[i].cv, vecs[i].ct);
      #2;
      check($sformatf("v%0d wen", i),      64'(rst_wen_onehot), 64'(vecs[i].wen));
      check($sformatf("v%0d rs_busy", i),  64'(rst_rs_busy),    64'(vecs[i].rsb));
      check($sformatf("v%0d rs_tag", i),   64'(rst_rs_tag),     64'(vecs[i].rst));
      check($sformatf("v%0d rs_fwd", i),   64'(rst_rs_cdbfwd),  64'(vecs[i].rsf));
      check($sformatf("v%0d rt_busy", i),  64'(rst_rt_busy),    64'(vecs[i].rtb));
      check($sformatf("v%0d rt_tag", i),   64'(rst_rt_tag),     64'(vecs[i].rtt));
      check($sformatf("v%0d rt_fwd", i),   64'(rst_rt_cdbfwd),  64'(vecs[i].rtf));
      check($sformatf("v%0d count", i),    64'(rst_busy_count), 64'(vecs[i].cnt));
      @(negedge clk);
    end

    // Build up five busy entries (regs 1..5, tags 40..44), then reset mid-run
    for (int r = 1; r <= 5; r++) begin
      drive(1'b0, 1'b1, W_ADDR'(r), W_TAG'(39 + r), 5'd0, 5'd0, 1'b0, 6'd0);
      @(negedge clk);
    end
    idle();
    dispatch_rsaddr = 5'd2;
    #2;
    check("pre-reset count", 64'(rst_busy_count), 64'd5);
    check("pre-reset rs2 busy", 64'(rst_rs_busy), 64'd1);
    check("pre-reset rs2 tag", 64'(rst_rs_tag), 64'd41);
    #1;
    reset = 1'b1;
    #1;
    check("in-reset count", 64'(rst_busy_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 6'd0, 5'd1, 5'd5, 1'b1, 6'd40);
    #2;
    check("post-reset wen", 64'(rst_wen_onehot), 64'd0);
    check("post-reset rs1 busy", 64'(rst_rs_busy), 64'd0);
    check("post-reset rt5 busy", 64'(rst_rt_busy), 64'd0);
    check("post-reset rs1 fwd", 64'(rst_rs_cdbfwd), 64'd0);
    check("post-reset count", 64'(rst_busy_count), 64'd0);
    @(negedge clk);
    idle();
    #2;
    check("post-reset count2", 64'(rst_busy_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
